note_sequencer: RTL and testbench

- Programmable note scheduler that drives the two-voice half-period frequency outputs, freq1 and freq2, of the tone generators.
- Holds a small note table; each entry is {freq1, freq2, duration}.
- On a play request it steps through the table with cycle-accurate note lengths, then outputs silence (0) when stopped or finished.
- Sits between the switch/control logic and the tone generators, and replaces hard-coded delay-based playback.

---
 rtl/note_sequencer.sv | 173 +++++++++++++++++
 tb/tb_note_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: two-voice note table player with tick-based note lengths.
// Define NOTE_SEQUENCER_LOOP_EN to add a loop input that restarts the song seamlessly.
module note_sequencer #(
  parameter int unsigned NUM_NOTES = 16,
  parameter int unsigned TICK_DIV  = 256,
  parameter int unsigned FREQ_W    = 8,
  parameter int unsigned DUR_W     = 8,
  localparam int unsigned IDX_W    = $clog2(NUM_NOTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [FREQ_W-1:0] wr_freq1,
  input  logic [FREQ_W-1:0] wr_freq2,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic              play,
  input  logic              stop,
`ifdef NOTE_SEQUENCER_LOOP_EN
  input  logic              loop,
`endif
  output logic [FREQ_W-1:0] freq1,
  output logic [FREQ_W-1:0] freq2,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  note_idx
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_NOTES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [FREQ_W-1:0] f1_q, f1_d, f2_q, f2_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic [FREQ_W-1:0] f1_mem [NUM_NOTES];
  logic [FREQ_W-1:0] f2_mem [NUM_NOTES];
  logic [DUR_W-1:0]  dur_mem [NUM_NOTES];

  logic              wr_ok_c, fwd0_c, last_c, loop_c;
  logic [IDX_W-1:0]  nx_idx_c;
  logic [FREQ_W-1:0] e0_f1_c, e0_f2_c;
  logic [DUR_W-1:0]  e0_dur_c;

  // Table is only writable while idle and is deliberately left out of reset.
  assign wr_ok_c = wr_en && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      f1_mem[wr_addr]  <= wr_freq1;
      f2_mem[wr_addr]  <= wr_freq2;
      dur_mem[wr_addr] <= wr_dur;
    end
  end

  // Entry 0 bypass so a same-edge write to entry 0 is what playback starts with.
  assign fwd0_c   = wr_ok_c && (wr_addr == '0);
  assign e0_f1_c  = fwd0_c ? wr_freq1 : f1_mem[0];
  assign e0_f2_c  = fwd0_c ? wr_freq2 : f2_mem[0];
  assign e0_dur_c = fwd0_c ? wr_dur   : dur_mem[0];

  assign nx_idx_c = idx_q + IDX_W'(1);
  assign last_c   = (idx_q == IDX_MAX) || (dur_mem[nx_idx_c] == '0);

`ifdef NOTE_SEQUENCER_LOOP_EN
  assign loop_c = loop && (e0_dur_c != '0);
`else
  assign loop_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // IDLE and DONE are always entered with outputs and counters already cleared.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (play) begin
          if (e0_dur_c != '0) begin
            state_d = ST_PLAY;
            f1_d    = e0_f1_c;
            f2_d    = e0_f2_c;
            dur_d   = e0_dur_c;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_PLAY: begin
        busy_d = 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          idx_d   = '0;
          tick_d  = '0;
          dur_d   = '0;
          f1_d    = '0;
          f2_d    = '0;
        end else if (tick_q != TICK_MAX) begin
          tick_d = tick_q + TICK_W'(1);
        end else begin
          tick_d = '0;
          if (dur_q != DUR_W'(1)) begin
            dur_d = dur_q - DUR_W'(1);
          end else if (!last_c) begin
            idx_d = nx_idx_c;
            f1_d  = f1_mem[nx_idx_c];
            f2_d  = f2_mem[nx_idx_c];
            dur_d = dur_mem[nx_idx_c];
          end else if (loop_c) begin
            done_d = 1'b1;
            idx_d  = '0;
            f1_d   = e0_f1_c;
            f2_d   = e0_f2_c;
            dur_d  = e0_dur_c;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            dur_d   = '0;
            f1_d    = '0;
            f2_d    = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign freq1    = f1_q;
  assign freq2    = f2_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: two instances (TICK_DIV 4 and 2) share clock and reset.
`timescale 1ns/1ps
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_wr_en, b_wr_en, a_play, b_play, stop;
  logic [3:0] wr_addr;
  logic [7:0] wr_freq1, wr_freq2, wr_dur;
`ifdef NOTE_SEQUENCER_LOOP_EN
  logic       loop;
`endif
  logic [7:0] a_f1, a_f2, b_f1, b_f2;
  logic       a_busy, a_done, b_busy, b_done;
  logic [3:0] a_idx, b_idx;

  always #5 clk = ~clk;

  note_sequencer #(.NUM_NOTES(16), .TICK_DIV(4), .FREQ_W(8), .DUR_W(8)) u_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_addr(wr_addr),
    .wr_freq1(wr_freq1), .wr_freq2(wr_freq2), .wr_dur(wr_dur),
    .play(a_play), .stop(stop),
`ifdef NOTE_SEQUENCER_LOOP_EN
    .loop(1'b0),
`endif
    .freq1(a_f1), .freq2(a_f2), .busy(a_busy), .done(a_done), .note_idx(a_idx));

  note_sequencer #(.NUM_NOTES(16), .TICK_DIV(2), .FREQ_W(8), .DUR_W(8)) u_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_addr(wr_addr),
    .wr_freq1(wr_freq1), .wr_freq2(wr_freq2), .wr_dur(wr_dur),
    .play(b_play), .stop(1'b0),
`ifdef NOTE_SEQUENCER_LOOP_EN
    .loop(loop),
`endif
    .freq1(b_f1), .freq2(b_f2), .busy(b_busy), .done(b_done), .note_idx(b_idx));

  typedef struct packed {
    logic [7:0] f1;
    logic [7:0] f2;
    logic       busy;
    logic       done;
    logic [3:0] idx;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    bit          sel;
    obs_t        exp;
    string       name;
  } rec_t;

  rec_t        q[$];
  int unsigned cyc;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every record due in the current cycle is popped and compared.
  always @(negedge clk) begin
    rec_t r;
    obs_t act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      r   = q.pop_front();
      act = r.sel ? {b_f1, b_f2, b_busy, b_done, b_idx} : {a_f1, a_f2, a_busy, a_done, a_idx};
      n_chk++;
      if (r.cyc != cyc || act !== r.exp) begin
        n_fail++;
        $display("FAIL %s dut=%0d cyc=%0d(due %0d) got f1=%0d f2=%0d busy=%0b done=%0b idx=%0d expected f1=%0d f2=%0d busy=%0b done=%0b idx=%0d",
                 r.name, r.sel, cyc, r.cyc, act.f1, act.f2, act.busy, act.done, act.idx,
                 r.exp.f1, r.exp.f2, r.exp.busy, r.exp.done, r.exp.idx);
      end
    end
  end

  task automatic push(input int unsigned c, input bit sel, input logic [7:0] f1, input logic [7:0] f2,
                      input logic bsy, input logic dn, input logic [3:0] idx, input string nm);
    rec_t r;
    r.cyc = c; r.sel = sel; r.exp = {f1, f2, bsy, dn, idx}; r.name = nm;
    q.push_back(r);
  endtask

  task automatic expect_note(input int unsigned c, input int unsigned len, input bit sel,
                             input logic [7:0] f1, input logic [7:0] f2, input logic [3:0] idx,
                             input string nm);
    for (int unsigned i = 0; i < len; i++) push(c + i, sel, f1, f2, 1'b1, 1'b0, idx, nm);
  endtask

  task automatic expect_idle(input int unsigned c, input bit sel, input logic dn, input string nm);
    push(c, sel, 8'd0, 8'd0, 1'b0, dn, 4'd0, nm);
  endtask

  // Song {(20,20,2),(5,20,1),end} at TICK_DIV 4 starting in cycle n.
  task automatic expect_song1(input int unsigned n, input string nm);
    expect_note(n, 8, 1'b0, 8'd20, 8'd20, 4'd0, nm);
    expect_note(n + 8, 4, 1'b0, 8'd5, 8'd20, 4'd1, nm);
    expect_idle(n + 12, 1'b0, 1'b1, nm);
    expect_idle(n + 13, 1'b0, 1'b0, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic wr(input bit sel, input logic [3:0] a, input logic [7:0] f1, input logic [7:0] f2,
                    input logic [7:0] d);
    wr_addr = a; wr_freq1 = f1; wr_freq2 = f2; wr_dur = d;
    if (sel) b_wr_en = 1'b1; else a_wr_en = 1'b1;
    step();
    a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d expected run to finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n, k;
    reset = 1'b1; a_wr_en = 1'b0; b_wr_en = 1'b0; a_play = 1'b0; b_play = 1'b0; stop = 1'b0;
    wr_addr = '0; wr_freq1 = '0; wr_freq2 = '0; wr_dur = '0;
`ifdef NOTE_SEQUENCER_LOOP_EN
    loop = 1'b0;
`endif
    step(); step();
    expect_idle(cyc, 1'b0, 1'b0, "reset_a");
    expect_idle(cyc, 1'b1, 1'b0, "reset_b");
    step();
    reset = 1'b0;
    step();

    wr(1'b0, 4'd0, 8'd20, 8'd20, 8'd2);
    wr(1'b0, 4'd1, 8'd5, 8'd20, 8'd1);
    wr(1'b0, 4'd2, 8'd0, 8'd0, 8'd0);

    n = cyc + 1; a_play = 1'b1; expect_song1(n, "song1");
    step(); a_play = 1'b0;
    goto(n + 14);

    // Stop 3 cycles into note 1, with an ignored write issued mid-play.
    n = cyc + 1; a_play = 1'b1;
    expect_note(n, 8, 1'b0, 8'd20, 8'd20, 4'd0, "stop_n0");
    expect_note(n + 8, 3, 1'b0, 8'd5, 8'd20, 4'd1, "stop_n1");
    expect_idle(n + 11, 1'b0, 1'b0, "stop_idle");
    expect_idle(n + 12, 1'b0, 1'b0, "stop_nodone");
    step(); a_play = 1'b0;
    step();
    wr(1'b0, 4'd1, 8'd99, 8'd99, 8'd9);
    goto(n + 10); stop = 1'b1;
    step(); stop = 1'b0;
    goto(n + 13);

    n = cyc + 1; a_play = 1'b1; stop = 1'b1; expect_song1(n, "replay_playstop");
    step(); a_play = 1'b0; stop = 1'b0;
    goto(n + 14);

    // Asynchronous reset at a random point of note 0.
    k = $urandom_range(7, 1);
    n = cyc + 1; a_play = 1'b1;
    expect_note(n, k, 1'b0, 8'd20, 8'd20, 4'd0, "pre_reset");
    expect_idle(n + k, 1'b0, 1'b0, "async_reset_a");
    expect_idle(n + k, 1'b1, 1'b0, "async_reset_b");
    step(); a_play = 1'b0;
    goto(n + k);
    #2 reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    n = cyc + 1; a_play = 1'b1; expect_song1(n, "post_reset");
    step(); a_play = 1'b0;
    goto(n + 14);

    // Same-edge write of a zero-duration entry 0 with play.
    n = cyc + 1;
    wr_addr = 4'd0; wr_freq1 = 8'd7; wr_freq2 = 8'd7; wr_dur = 8'd0; a_wr_en = 1'b1; a_play = 1'b1;
    expect_idle(n, 1'b0, 1'b1, "dur0_done");
    expect_idle(n + 1, 1'b0, 1'b0, "dur0_after");
    expect_idle(n + 2, 1'b0, 1'b0, "dur0_quiet");
    step(); a_wr_en = 1'b0; a_play = 1'b0;
    goto(n + 3);

    // Held play restarts after a 2-cycle silent gap; entry 0 rewritten on the start edge.
    n = cyc + 1;
    wr_addr = 4'd0; wr_freq1 = 8'd30; wr_freq2 = 8'd20; wr_dur = 8'd1; a_wr_en = 1'b1; a_play = 1'b1;
    expect_note(n, 4, 1'b0, 8'd30, 8'd20, 4'd0, "hold_r1n0");
    expect_note(n + 4, 4, 1'b0, 8'd5, 8'd20, 4'd1, "hold_r1n1");
    expect_idle(n + 8, 1'b0, 1'b1, "hold_done1");
    expect_idle(n + 9, 1'b0, 1'b0, "hold_gap");
    expect_note(n + 10, 4, 1'b0, 8'd30, 8'd20, 4'd0, "hold_r2n0");
    expect_note(n + 14, 4, 1'b0, 8'd5, 8'd20, 4'd1, "hold_r2n1");
    expect_idle(n + 18, 1'b0, 1'b1, "hold_done2");
    expect_idle(n + 19, 1'b0, 1'b0, "hold_idle");
    step(); a_wr_en = 1'b0;
    goto(n + 10); a_play = 1'b0;
    goto(n + 20);

    // Full 16-entry walk at TICK_DIV 2.
    for (int i = 0; i < 16; i++) wr(1'b1, 4'(i), 8'(i + 1), 8'(100 + i), 8'd1);
    n = cyc + 1; b_play = 1'b1;
    for (int i = 0; i < 16; i++)
      expect_note(n + 2 * i, 2, 1'b1, 8'(i + 1), 8'(100 + i), 4'(i), "walk16");
    expect_idle(n + 32, 1'b1, 1'b1, "walk16_done");
    expect_idle(n + 33, 1'b1, 1'b0, "walk16_idle");
    step(); b_play = 1'b0;
    goto(n + 34);

`ifdef NOTE_SEQUENCER_LOOP_EN
    wr(1'b1, 4'd0, 8'd11, 8'd12, 8'd1);
    wr(1'b1, 4'd1, 8'd13, 8'd14, 8'd1);
    wr(1'b1, 4'd2, 8'd0, 8'd0, 8'd0);
    n = cyc + 1; b_play = 1'b1; loop = 1'b1;
    expect_note(n, 2, 1'b1, 8'd11, 8'd12, 4'd0, "loop_p1n0");
    expect_note(n + 2, 2, 1'b1, 8'd13, 8'd14, 4'd1, "loop_p1n1");
    push(n + 4, 1'b1, 8'd11, 8'd12, 1'b1, 1'b1, 4'd0, "loop_wrap");
    expect_note(n + 5, 1, 1'b1, 8'd11, 8'd12, 4'd0, "loop_p2n0");
    expect_note(n + 6, 2, 1'b1, 8'd13, 8'd14, 4'd1, "loop_p2n1");
    expect_idle(n + 8, 1'b1, 1'b1, "loop_end_done");
    expect_idle(n + 9, 1'b1, 1'b0, "loop_end_idle");
    step(); b_play = 1'b0;
    goto(n + 5); loop = 1'b0;
    goto(n + 10);
`endif

    step(); step();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
